// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   npc_op_t      : next-PC operation encoding used by the core's redirect path
//   fetch_state_t : fetch FSM state encoding
//   RESET_PC_DEFAULT : PC loaded on reset unless the top is overridden
package fetch_pkg;

  typedef enum logic [1:0] {
    NPC_PC4  = 2'b00,
    NPC_JALR = 2'b01,
    NPC_BR   = 2'b10
  } npc_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    HOLD = 2'b11
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/npc_target.sv
// Redirect target calculation (purely combinational).
// Ports:
//   op_i          : next-PC op (00 pc+4, 01 jalr, 10 branch/jal)
//   br_pc_i       : PC of the redirecting instruction
//   rd1_i         : jalr base register value
//   imm_i         : sign-extended immediate
//   target_o      : redirect target address
//   redir_o       : op actually changes control flow (jalr or branch/jal)
//   misaligned_o  : target bit1 set, i.e. not 4-byte aligned
module npc_target
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic [XLEN-1:0] rd1_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] target_o,
  output logic            redir_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] br_sum;

  // Both sums wrap at XLEN bits; overflow is architecturally irrelevant here.
  assign jalr_sum = rd1_i + imm_i;
  assign br_sum   = br_pc_i + imm_i;

  always_comb begin
    target_o = '0;
    redir_o  = 1'b0;
    case (op_i)
      NPC_JALR: begin
        target_o = jalr_sum & ~XLEN'(1);
        redir_o  = 1'b1;
      end
      NPC_BR: begin
        target_o = br_sum;
        redir_o  = 1'b1;
      end
      default: begin
        target_o = '0;
        redir_o  = 1'b0;
      end
    endcase
  end

  assign misaligned_o = target_o[1];

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding request
// at a time to instruction memory, buffers the returned word for decode and
// applies control-flow redirects, discarding stale in-flight responses.
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset release, no request
// REQ   | imem_req high at pc, waiting for grant
// WAIT  | request granted, waiting for rvalid (dropped if drop_q set)
// HOLD  | output buffer valid, waiting for decode to accept it
//
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   redirect_valid_i/op_i    : redirect request and next-PC op
//   br_pc_i, rd1_i, imm_i    : redirect target operands
//   imem_req_o, imem_addr_o  : fetch request and address
//   imem_gnt_i               : request accepted
//   imem_rvalid_i/rdata_i    : response valid and instruction word
//   inst_valid_o, inst_o     : output buffer valid and instruction
//   inst_pc_o, inst_pc4_o    : PC of buffered instruction and PC+4
//   id_ready_i               : decode consumes the buffer
//   misalign_err_o           : one-cycle pulse for a misaligned redirect target
module fetch_seq_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_valid_i,
  input  logic [1:0]      redirect_op_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic [XLEN-1:0] rd1_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic [XLEN-1:0] inst_pc4_o,
  input  logic            id_ready_i,
  output logic            misalign_err_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            inst_valid_q, inst_valid_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] inst_pc4_q, inst_pc4_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] tgt;
  logic            tgt_redir;
  logic            tgt_misaligned;
  logic            redir_act;
  logic            redir_take;
  logic [XLEN-1:0] pc_plus4;

  npc_target #(
    .XLEN (XLEN)
  ) u_npc_target (
    .op_i         (redirect_op_i),
    .br_pc_i      (br_pc_i),
    .rd1_i        (rd1_i),
    .imm_i        (imm_i),
    .target_o     (tgt),
    .redir_o      (tgt_redir),
    .misaligned_o (tgt_misaligned)
  );

  assign redir_act  = redirect_valid_i & tgt_redir;
  assign redir_take = redir_act & ~tgt_misaligned;
  assign pc_plus4   = pc_q + XLEN'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_pc4_d   = inst_pc4_q;
    misalign_d   = redir_act & tgt_misaligned;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d       = imem_rdata_i;
            inst_pc_d    = pc_q;
            inst_pc4_d   = pc_plus4;
            inst_valid_d = 1'b1;
            pc_d         = pc_plus4;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (id_ready_i) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A taken redirect overrides everything above; buffer contents stay
    // as they were, only the valid flag is cleared.
    if (redir_take) begin
      pc_d         = tgt;
      inst_valid_d = 1'b0;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_pc4_d   = inst_pc4_q;
      drop_d       = 1'b0;
      case (state_q)
        REQ: begin
          // A grant this cycle was for the old pc; its response must die.
          if (imem_gnt_i) begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            state_d = REQ;
          end else begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_pc4_q   <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_pc4_q   <= inst_pc4_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req_o     = (state_q == REQ);
  assign imem_addr_o    = pc_q;
  assign inst_valid_o   = inst_valid_q;
  assign inst_o         = inst_q;
  assign inst_pc_o      = inst_pc_q;
  assign inst_pc4_o     = inst_pc4_q;
  assign misalign_err_o = misalign_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
module tb_fetch_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [1:0]  redirect_op;
  logic [31:0] br_pc;
  logic [31:0] rd1;
  logic [31:0] imm;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        id_ready;
  logic        misalign_err;

  int checks;
  int failures;

  fetch_seq_ctrl #(
    .RESET_PC (32'h0000_0000),
    .XLEN     (32)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_op_i    (redirect_op),
    .br_pc_i          (br_pc),
    .rd1_i            (rd1),
    .imm_i            (imm),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_gnt_i       (imem_gnt),
    .imem_rvalid_i    (imem_rvalid),
    .imem_rdata_i     (imem_rdata),
    .inst_valid_o     (inst_valid),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc),
    .inst_pc4_o       (inst_pc4),
    .id_ready_i       (id_ready),
    .misalign_err_o   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_op = 2'b00;
    br_pc = '0;
    rd1 = '0;
    imm = '0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    id_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_pc4", inst_pc4, 32'd0);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);

    // Cycle N: reset released, IDLE
    rst = 1'b0;
    check("idle_req", {31'b0, imem_req}, 32'd0);
    tick();
    // N+1: REQ at RESET_PC, granted immediately
    check("n1_req", {31'b0, imem_req}, 32'd1);
    check("n1_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    tick();
    // N+2: WAIT, response arrives
    imem_gnt = 1'b0;
    check("n2_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_0013;
    tick();
    // N+3: HOLD
    imem_rvalid = 1'b0;
    check("n3_valid", {31'b0, inst_valid}, 32'd1);
    check("n3_inst", inst, 32'h0000_0013);
    check("n3_inst_pc", inst_pc, 32'h0);
    check("n3_inst_pc4", inst_pc4, 32'h4);

    // Decode stalls 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'b0, inst_valid}, 32'd1);
      check("stall_inst", inst, 32'h0000_0013);
      check("stall_inst_pc", inst_pc, 32'h0);
      check("stall_req", {31'b0, imem_req}, 32'd0);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("accept_valid", {31'b0, inst_valid}, 32'd0);
    check("accept_req", {31'b0, imem_req}, 32'd1);
    check("accept_addr", imem_addr, 32'h4);

    // Fetch at 4
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hAAAA_0001;
    tick();
    imem_rvalid = 1'b0;
    check("f4_inst", inst, 32'hAAAA_0001);
    check("f4_inst_pc", inst_pc, 32'h4);
    check("f4_inst_pc4", inst_pc4, 32'h8);

    // jalr redirect in HOLD with id_ready also high: (0x1001+4)&~1 = 0x1004
    redirect_valid = 1'b1;
    redirect_op = 2'b01;
    rd1 = 32'h0000_1001;
    imm = 32'h4;
    id_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    check("jalr_valid", {31'b0, inst_valid}, 32'd0);
    check("jalr_req", {31'b0, imem_req}, 32'd1);
    check("jalr_addr", imem_addr, 32'h1004);
    check("jalr_misalign", {31'b0, misalign_err}, 32'd0);

    // Branch redirect while in WAIT: 0x40 + (-16) = 0x30; stale rvalid next cycle
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_op = 2'b10;
    br_pc = 32'h40;
    imm = 32'hFFFF_FFF0;
    tick();
    redirect_valid = 1'b0;
    check("br_wait_req", {31'b0, imem_req}, 32'd0);
    check("br_wait_valid", {31'b0, inst_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("br_drop_valid", {31'b0, inst_valid}, 32'd0);
    check("br_req", {31'b0, imem_req}, 32'd1);
    check("br_addr", imem_addr, 32'h30);

    // Misaligned redirect: 0 + 6 = 6, bit1 set
    redirect_valid = 1'b1;
    redirect_op = 2'b10;
    br_pc = 32'h0;
    imm = 32'h6;
    tick();
    redirect_valid = 1'b0;
    check("mis_pulse", {31'b0, misalign_err}, 32'd1);
    check("mis_addr", imem_addr, 32'h30);
    check("mis_req", {31'b0, imem_req}, 32'd1);
    tick();
    check("mis_pulse_end", {31'b0, misalign_err}, 32'd0);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_0093;
    tick();
    imem_rvalid = 1'b0;
    check("seq_inst", inst, 32'h0000_0093);
    check("seq_inst_pc", inst_pc, 32'h30);
    check("seq_inst_pc4", inst_pc4, 32'h34);

    // op 00 with redirect_valid: no effect
    redirect_valid = 1'b1;
    redirect_op = 2'b00;
    br_pc = 32'h100;
    imm = 32'h8;
    tick();
    redirect_valid = 1'b0;
    check("op00_valid", {31'b0, inst_valid}, 32'd1);
    check("op00_misalign", {31'b0, misalign_err}, 32'd0);
    check("op00_inst_pc", inst_pc, 32'h30);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("op00_addr", imem_addr, 32'h34);

    // Redirect on the same cycle as grant: granted response is dropped
    imem_gnt = 1'b1;
    redirect_valid = 1'b1;
    redirect_op = 2'b01;
    rd1 = 32'h200;
    imm = 32'h0;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b0;
    check("gntredir_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_1111;
    tick();
    imem_rvalid = 1'b0;
    check("gntredir_valid", {31'b0, inst_valid}, 32'd0);
    check("gntredir_req2", {31'b0, imem_req}, 32'd1);
    check("gntredir_addr", imem_addr, 32'h200);

    // Reset in WAIT; stale response after release is ignored
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    check("wrst_req", {31'b0, imem_req}, 32'd0);
    check("wrst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    check("wrst_stale_valid", {31'b0, inst_valid}, 32'd0);
    check("wrst_req2", {31'b0, imem_req}, 32'd1);
    check("wrst_addr2", imem_addr, 32'h0);
    imem_rvalid = 1'b0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("wrst_wait_valid", {31'b0, inst_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_0013;
    tick();
    imem_rvalid = 1'b0;
    check("wrst_inst_valid", {31'b0, inst_valid}, 32'd1);
    check("wrst_inst", inst, 32'h0000_0013);
    check("wrst_inst_pc", inst_pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
